iir_inverse: RTL and testbench

Inverse (deconvolution) stage for the first-order low-pass `iir` filter. The filter computes y[n] = y[n-1] + 0.921875·(x[n] − y[n-1]). This block takes the filter's integer output stream and reconstructs x[n] = y[n-1] + (y[n] − y[n-1])·64/59. Division by the constant 59 uses a multi-cycle restoring divider, so the block is a busy/idle elastic stage with ready/valid on both sides. It sits at the receive end of a filtered sample link, downstream of `iir`.

---
 rtl/iir_inverse.sv | 117 +++++++++++
 tb/tb_iir_inverse.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_inverse.sv
// iir_inverse: undoes the first-order low-pass iir filter by reconstructing
// x[n] = y[n-1] + (y[n] - y[n-1]) * 64/59. The divide by 59 is a serial
// restoring divider, so the block accepts one sample, works on it for
// width_p+6 cycles, presents the result and waits for the downstream to take it.
module iir_inverse #(
  parameter int width_p = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);

  // Quotient bits to produce. |diff|*64 always fits in N bits because
  // |diff| never exceeds 2^width_p - 1 for in-range samples.
  localparam int N  = width_p + 6;
  localparam int CW = $clog2(N);

  localparam logic [6:0]         DIVISOR = 7'd59;
  localparam logic [width_p-1:0] OMAX    = {1'b0, {(width_p-1){1'b1}}};
  localparam logic [width_p-1:0] OMIN    = {1'b1, {(width_p-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t               state;
  logic [width_p-1:0]   y_prev;
  logic [width_p-1:0]   base;
  logic                 neg;
  logic [N-1:0]         dvd;
  logic [5:0]           rem;
  logic [width_p:0]     quo;
  logic [CW-1:0]        cnt;

  // Accept-side arithmetic: signed difference, its magnitude and the
  // pre-scaled dividend |diff|*64.
  logic [width_p:0]     diff;
  logic [width_p:0]     mag;
  logic [N-1:0]         dvd_init;
  assign diff     = {data_i[width_p-1], data_i} - {y_prev[width_p-1], y_prev};
  assign mag      = diff[width_p] ? (~diff + 1'b1) : diff;
  assign dvd_init = N'({mag, 6'b0});

  // One restoring division step: bring in the next dividend bit, subtract
  // the divisor when it fits. The partial remainder stays below 59 so six
  // stored bits are enough.
  logic [6:0]           rem_sh;
  logic                 ge;
  logic [5:0]           rem_d;
  assign rem_sh = {rem, dvd[N-1]};
  assign ge     = rem_sh >= DIVISOR;
  assign rem_d  = ge ? 6'(rem_sh - DIVISOR) : rem_sh[5:0];

  // Fix-up: apply sign (truncation toward zero), add the base and clamp.
  logic [width_p+1:0]        q_mag;
  logic [width_p+1:0]        q_sgn;
  logic signed [width_p+1:0] sum;
  logic [width_p-1:0]        sat;
  assign q_mag = {1'b0, quo};
  assign q_sgn = neg ? (~q_mag + 1'b1) : q_mag;
  assign sum   = $signed({{2{base[width_p-1]}}, base} + q_sgn);
  assign sat   = (sum > $signed({2'b00, OMAX})) ? OMAX :
                 (sum < $signed({2'b11, OMIN})) ? OMIN : sum[width_p-1:0];

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      data_o  <= '0;
      y_prev  <= '0;
      base    <= '0;
      neg     <= 1'b0;
      dvd     <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          neg     <= diff[width_p];
          dvd     <= dvd_init;
          base    <= y_prev;
          y_prev  <= data_i;
          rem     <= '0;
          quo     <= '0;
          cnt     <= '0;
          ready_o <= 1'b0;
          state   <= DIV;
        end
        DIV: begin
          dvd <= {dvd[N-2:0], 1'b0};
          rem <= rem_d;
          quo <= {quo[width_p-1:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N-1)) state <= FIX;
        end
        FIX: begin
          data_o  <= sat;
          valid_o <= 1'b1;
          state   <= DONE;
        end
        DONE: if (ready_i) begin
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_inverse.sv
// Bench for iir_inverse: directed samples with hand-computed results, an
// integer model of the inverse driving a scoreboard, and a round trip through
// a behavioural model of the forward iir filter.
module tb_iir_inverse;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic         ready_i = 1'b1;

  int total = 0;
  int bad = 0;
  int xfers = 0;

  typedef struct {
    int exp;
    int x;
    bit rt;
  } ent_t;
  ent_t sb[$];
  int   y_prev_m = 0;

  iir_inverse #(.width_p(W)) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .valid_i(valid_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o (data_o),
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reconstructed sample from the defining equation, using integer division
  // (truncates toward zero) and clamping to the output range.
  function automatic int model(input int x);
    int q, s;
    q = ((x - y_prev_m) * 64) / 59;
    s = y_prev_m + q;
    if (s > 511) s = 511;
    if (s < -512) s = -512;
    y_prev_m = x;
    return s;
  endfunction

  // Scoreboard: every output transfer is checked against the model.
  always @(negedge clk) begin
    if (!reset_i && valid_o) begin
      chk("ready_low_while_valid", int'(ready_o), 0);
      if (ready_i) begin
        xfers++;
        if (sb.size() == 0) begin
          chk("unexpected_output", sx(data_o), 9999);
        end else begin
          ent_t e;
          e = sb.pop_front();
          chk("data_o_vs_model", sx(data_o), e.exp);
          if (e.rt) begin
            int err;
            err = sx(data_o) - e.x;
            if (err < 0) err = -err;
            chk("roundtrip_err_le_2", int'(err <= 2), 1);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    sb.delete();
    y_prev_m = 0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
  endtask

  // Wait for ready_o (bounded), present one sample for one edge, record the
  // model prediction. lit >= -1000 pins the model to a hand-computed value.
  task automatic send(input int x, input int lit, input bit rt, input bit rnd_rdy);
    ent_t e;
    int   n;
    n = 0;
    while (!ready_o && n < 300) begin
      if (rnd_rdy) ready_i = 1'($urandom_range(1));
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    e.exp = model(x);
    e.x   = x;
    e.rt  = rt;
    if (lit > -1000) chk("model_literal", e.exp, lit);
    sb.push_back(e);
    valid_i = 1'b1;
    data_i  = W'(x);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // After an accept, count edges to valid_o and check the hand value.
  task automatic wait_out(input int lit);
    int k;
    k = 0;
    while (!valid_o && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency_edges", k, 17);
    chk("data_o_literal", sx(data_o), lit);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0, yf, x;
    #12;
    chk("reset_ready_o", int'(ready_o), 1);
    chk("reset_valid_o", int'(valid_o), 0);
    chk("reset_data_o", sx(data_o), 0);
    #1 reset_i = 1'b0;

    // basic inverse
    send(59, 64, 0, 0);  wait_out(64);
    send(59, 59, 0, 0);  wait_out(59);
    send(0, -5, 0, 0);   wait_out(-5);

    // truncation toward zero
    do_reset();
    send(10, 10, 0, 0);  wait_out(10);
    send(-10, -11, 0, 0); wait_out(-11);

    // saturation both ways
    do_reset();
    send(511, 511, 0, 0);   wait_out(511);
    send(-512, -512, 0, 0); wait_out(-512);

    // backpressure: DONE holds with upstream still pushing
    do_reset();
    ready_i = 1'b0;
    send(59, 64, 0, 0);
    repeat (17) @(posedge clk);
    #1;
    chk("bp_valid_up", int'(valid_o), 1);
    n0 = xfers;
    for (int i = 0; i < 20; i++) begin
      valid_i = 1'b1;
      data_i  = W'($urandom_range(1023));
      @(negedge clk);
      chk("bp_valid_hold", int'(valid_o), 1);
      chk("bp_data_hold", sx(data_o), 64);
      chk("bp_ready_low", int'(ready_o), 0);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      chk("bp_no_extra_valid", int'(valid_o), 0);
    end
    chk("bp_one_transfer", xfers - n0, 1);

    // asynchronous reset in the middle of a division
    do_reset();
    send(100, 108, 0, 0);
    repeat (5) @(posedge clk);
    #3;
    reset_i = 1'b1;
    sb.delete();
    y_prev_m = 0;
    #1;
    chk("midreset_valid_o", int'(valid_o), 0);
    chk("midreset_ready_o", int'(ready_o), 1);
    chk("midreset_data_o", sx(data_o), 0);
    @(posedge clk); #1 reset_i = 1'b0;
    n0 = xfers;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      chk("midreset_no_pulse", int'(valid_o), 0);
    end
    chk("midreset_no_xfer", xfers - n0, 0);
    send(59, 64, 0, 0);  wait_out(64);

    // round trip through a forward iir model, random downstream stalls
    do_reset();
    yf = 0;
    for (int i = 0; i < 40; i++) begin
      x  = int'($urandom_range(800)) - 400;
      yf = yf + ((59 * (x - yf)) >>> 6);
      send(yf, -2000, 1, 1);
      send_hold_x(x);
    end
    ready_i = 1'b1;
    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("roundtrip_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Replace the original-x field of the entry just queued with the filter
  // input, so the scoreboard can bound the reconstruction error.
  task automatic send_hold_x(input int x);
    if (sb.size() != 0) sb[sb.size()-1].x = x;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
